// File: rtl/uart_rx_os16_if.sv
// Receive-side byte handshake between the UART receiver and its consumer
// (APB RX register or FIFO).
interface uart_rx_os16_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_os16.sv
// 8N1 UART receiver with 16x oversampling: mid-bit sampling, glitch-rejecting
// start detection, valid/ready output register, sticky overrun and frame-error pulse.
module uart_rx_os16 (
  input  logic           pclk,
  input  logic           prst,
  input  logic           baud_tick,
  input  logic           rx,
  input  logic           ovr_clr,
  output logic           frame_err,
  output logic           overrun,
  output logic           busy,
  uart_rx_os16_if.master rx_if
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_sync1;
  logic        r_sync2;
  logic [3:0]  r_tick_cnt;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_shift;
  logic [7:0]  r_rx_data;
  logic        r_rx_valid;
  logic        r_frame_err;
  logic        r_overrun;

  state_t      w_state_nxt;
  logic [3:0]  w_tick_nxt;
  logic [2:0]  w_bit_nxt;
  logic [7:0]  w_shift_nxt;
  logic        w_rx_s;
  logic        w_done;
  logic        w_bad;
  logic        w_take;

  assign w_rx_s = r_sync2;
  assign w_take = r_rx_valid & rx_if.rx_ready;

  // Two-flop synchronizer for the asynchronous serial line.
  always_ff @(posedge pclk) begin
    if (prst) begin
      // NOTE: reset to the idle level (1) so leaving reset never looks like a start edge.
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make both flops sample the old values,
      // giving two real stages; blocking here would collapse them into one.
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  // Next-state logic; counters and shift register move only on baud ticks.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick_cnt;
    w_bit_nxt   = r_bit_cnt;
    w_shift_nxt = r_shift;
    w_done      = 1'b0;
    w_bad       = 1'b0;
    if (baud_tick) begin
      unique case (r_state)
        IDLE: begin
          if (!w_rx_s) begin
            w_state_nxt = START;
            w_tick_nxt  = 4'd0;
          end
        end
        START: begin
          if (r_tick_cnt == 4'd7) begin
            w_tick_nxt = 4'd0;
            if (!w_rx_s) begin
              w_state_nxt = DATA;
              w_bit_nxt   = 3'd0;
            end else begin
              w_state_nxt = IDLE;
            end
          end else begin
            w_tick_nxt = r_tick_cnt + 4'd1;
          end
        end
        DATA: begin
          if (r_tick_cnt == 4'd15) begin
            w_shift_nxt = {w_rx_s, r_shift[7:1]};
            w_tick_nxt  = 4'd0;
            if (r_bit_cnt == 3'd7) begin
              w_state_nxt = STOP;
            end else begin
              w_bit_nxt = r_bit_cnt + 3'd1;
            end
          end else begin
            w_tick_nxt = r_tick_cnt + 4'd1;
          end
        end
        STOP: begin
          if (r_tick_cnt == 4'd15) begin
            w_state_nxt = IDLE;
            w_tick_nxt  = 4'd0;
            w_done      = w_rx_s;
            w_bad       = ~w_rx_s;
          end else begin
            w_tick_nxt = r_tick_cnt + 4'd1;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_tick_nxt  = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      r_state    <= IDLE;
      r_tick_cnt <= 4'd0;
      r_bit_cnt  <= 3'd0;
      r_shift    <= 8'h00;
    end else begin
      r_state    <= w_state_nxt;
      r_tick_cnt <= w_tick_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_shift    <= w_shift_nxt;
    end
  end

  // Output register: a completed byte loads only if the slot is empty or being drained.
  always_ff @(posedge pclk) begin
    if (prst) begin
      r_rx_data   <= 8'h00;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_bad;
      if (w_done && (!r_rx_valid || w_take)) begin
        r_rx_data  <= r_shift;
        r_rx_valid <= 1'b1;
      end else if (w_take) begin
        r_rx_valid <= 1'b0;
      end
      if (w_done && r_rx_valid && !w_take) begin
        r_overrun <= 1'b1;
      end else if (ovr_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign rx_if.rx_data  = r_rx_data;
  assign rx_if.rx_valid = r_rx_valid;
  assign frame_err      = r_frame_err;
  assign overrun        = r_overrun;
  assign busy           = (r_state != IDLE);

endmodule

// File: doc/uart_rx_os16.md
UART_RX_OS16 -- requirements
Module: uart_rx_os16

Interface
REQ-001 Parameters: none; frame format is fixed at 1 start, 8 data bits LSB first, no parity, 1 stop; oversampling fixed at 16.
REQ-002 pclk  input  1  single clock; all state updates on its rising edge.
REQ-003 prst  input  1  reset, synchronous, active-high.
REQ-004 baud_tick  input  1  one-pclk-wide pulse at 16x baud rate (from baud generator).
REQ-005 rx  input  1  asynchronous serial line, idle high.
REQ-006 rx_ready  input  1  downstream (APB RX register/FIFO) accepts rx_data when high with rx_valid.
REQ-007 ovr_clr  input  1  single-cycle clear of overrun flag.
REQ-008 rx_data  output  8  received byte; stable while rx_valid high.
REQ-009 rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-010 frame_err  output  1  one-pclk pulse: stop bit sampled low.
REQ-011 overrun  output  1  sticky: completed frame dropped because previous byte unconsumed.
REQ-012 busy  output  1  high whenever FSM not in IDLE.

Function
REQ-013 rx SHALL pass through a 2-flop synchronizer (both flops reset to 1); all sampling uses synchronized rx_s.
REQ-014 FSM states SHALL be IDLE, START, DATA, STOP; tick counter (4 bits) and bit counter (3 bits) advance only on cycles with baud_tick=1.
REQ-015 IDLE: on baud_tick with rx_s=0 -> START, tick_cnt=0.
REQ-016 START: tick_cnt increments per tick; on the tick where tick_cnt==7, rx_s=0 -> DATA (tick_cnt=0, bit_cnt=0); rx_s=1 -> IDLE (glitch rejected, no outputs change).
REQ-017 DATA: on the tick where tick_cnt==15, sample rx_s into shift register (shift right, new bit into MSB), tick_cnt=0; after sampling with bit_cnt==7 -> STOP, else bit_cnt+1.
REQ-018 STOP: on the tick where tick_cnt==15, sample rx_s and -> IDLE; rx_s=1 completes frame, rx_s=0 pulses frame_err one cycle and discards byte.
REQ-019 Frame completion SHALL assert rx_valid and load rx_data on the pclk edge following the stop-sampling tick cycle (latency 1 pclk).
REQ-020 Handshake: rx_valid clears on the cycle after rx_valid&&rx_ready; rx_data unchanged while rx_valid=1 and not accepted.
REQ-021 Completion while rx_valid=1 and rx_ready=0: keep old rx_data, drop new byte, set overrun.
REQ-022 Completion in same cycle as acceptance (rx_valid&&rx_ready): load new byte, rx_valid stays 1, no overrun.
REQ-023 ovr_clr clears overrun; simultaneous set and ovr_clr -> set wins.
REQ-024 Frame error never sets overrun and never alters rx_valid/rx_data.
REQ-025 busy SHALL be 0 in IDLE, 1 in START/DATA/STOP.
REQ-026 rx changes between ticks SHALL have no effect beyond synchronizer flops.

Reset
REQ-027 prst=1 at a rising edge SHALL force: FSM IDLE, counters 0, shift register 0, rx_data=0x00, rx_valid=0, frame_err=0, overrun=0, busy=0, sync flops=1.
REQ-028 Reset mid-frame SHALL discard the partial byte; reception restarts only on a fresh start edge after prst deasserts.

Verification (baud_tick every 4 pclk, 64 pclk per bit)
REQ-029 Hold prst 3 cycles -> all outputs 0, busy 0; release with rx=1 for 2 bit times -> no change.
REQ-030 Send 0xA1, rx_ready=1 -> rx_data=0xA1, rx_valid high exactly 1 cycle, frame_err=0, overrun=0, busy falls in stop mid-bit.
REQ-031 rx low for 4 ticks then high -> START then IDLE, busy returns 0, rx_valid never asserts.
REQ-032 Send 0x55 with stop bit 0 -> frame_err 1-cycle pulse, rx_valid stays 0; next frame 0x0F received correctly.
REQ-033 rx_ready=0, send 0x3C then 0xC3 -> rx_data=0x3C held, overrun=1; pulse ovr_clr -> overrun=0; rx_ready=1 -> 0x3C consumed.
REQ-034 Assert prst during data bit 4 of 0xFF -> IDLE, outputs reset; then send 0x7E -> rx_data=0x7E valid.
